// File: rtl/johnson_phase_monitor.sv
// Johnson-code phase monitor.
// Decodes the upstream Johnson counter into a phase index and a one-hot
// vector. It tracks legal successor steps to declare lock and latches a
// sticky error when a locked sequence breaks. It also counts completed
// revolutions while locked.
module johnson_phase_monitor #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 4,
  parameter int REV_W      = 8
) (
  input  logic                          Clock,
  input  logic                          Reset_n,
  input  logic [WIDTH-1:0]              Count_in,
  input  logic                          Clear_err,
  output logic [$clog2(2*WIDTH)-1:0]    Phase_out,
  output logic [2*WIDTH-1:0]            Phase_onehot,
  output logic                          Phase_valid,
  output logic                          Locked,
  output logic                          Error,
  output logic [REV_W-1:0]              Rev_count,
  output logic                          Rev_tick
);

  localparam int NPH   = 2 * WIDTH;
  localparam int PH_W  = $clog2(NPH);
  localparam int RUN_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  // Returns {legal, phase}. The code is legal when its ones are packed
  // from the LSB (phase = count of ones), or when its zeros are packed
  // from the LSB (phase = N + count of zeros).
  function automatic logic [PH_W:0] decode_johnson(input logic [WIDTH-1:0] code);
    logic [PH_W:0] res;
    res = '0;
    for (int k = 0; k <= WIDTH; k++) begin
      if (code == WIDTH'((1 << k) - 1))
        res = {1'b1, PH_W'(k)};
    end
    for (int k = 1; k < WIDTH; k++) begin
      if (code == WIDTH'(~((1 << k) - 1)))
        res = {1'b1, PH_W'(WIDTH + k)};
    end
    return res;
  endfunction

  state_t            state, state_nxt;
  logic [RUN_W-1:0]  run, run_nxt;
  logic [PH_W-1:0]   phase_p1;
  logic              vld_p1;
  logic              dec_legal;
  logic [PH_W-1:0]   dec_phase;
  logic [PH_W-1:0]   succ_phase;
  logic              is_hold;
  logic              is_step;
  logic              seq_fault;
  logic              rev_hit;

  assign {dec_legal, dec_phase} = decode_johnson(Count_in);

  // Successor of the last legal phase, wrapping 2N-1 -> 0.
  assign succ_phase = (phase_p1 == PH_W'(NPH - 1)) ? '0 : phase_p1 + PH_W'(1);
  assign is_hold    = dec_legal && (dec_phase == phase_p1);
  assign is_step    = dec_legal && (dec_phase == succ_phase);
  assign seq_fault  = (state == S_LOCKED) && !(is_step || is_hold);
  assign rev_hit    = (state == S_LOCKED) && is_step && (phase_p1 == PH_W'(NPH - 1));

  // FSM state and consecutive-step run counter.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_SEARCH;
      run   <= '0;
    end else begin
      state <= state_nxt;
      run   <= run_nxt;
    end
  end

  // Next-state logic: build up a run of STEPs to lock, and trip on any
  // break once locked.
  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    case (state)
      S_SEARCH: begin
        if (dec_legal) begin
          state_nxt = S_TRACK;
          run_nxt   = '0;
        end
      end
      S_TRACK: begin
        if (is_step) begin
          run_nxt = run + RUN_W'(1);
          if (run_nxt == RUN_W'(LOCK_COUNT))
            state_nxt = S_LOCKED;
        end else if (!is_hold) begin
          state_nxt = S_SEARCH;
        end
      end
      S_LOCKED: begin
        if (seq_fault)
          state_nxt = S_FAULT;
      end
      S_FAULT: begin
        if (Clear_err)
          state_nxt = S_SEARCH;
      end
      default: state_nxt = S_SEARCH;
    endcase
  end

  // FSM-derived outputs: lock indication and the one-hot phase view.
  always_comb begin
    Locked       = (state == S_LOCKED);
    Phase_onehot = '0;
    if (vld_p1)
      Phase_onehot[phase_p1] = 1'b1;
  end

  // Decode register: an illegal sample keeps the last legal phase.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      phase_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= dec_legal;
      if (dec_legal)
        phase_p1 <= dec_phase;
    end
  end

  // Sticky error: a new fault beats a simultaneous clear.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)
      Error <= 1'b0;
    else if (seq_fault)
      Error <= 1'b1;
    else if (Clear_err)
      Error <= 1'b0;
  end

  // Revolution counter and tick on the locked 2N-1 -> 0 wrap.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Rev_count <= '0;
      Rev_tick  <= 1'b0;
    end else begin
      Rev_tick <= rev_hit;
      if (rev_hit)
        Rev_count <= Rev_count + REV_W'(1);
    end
  end

  assign Phase_out   = phase_p1;
  assign Phase_valid = vld_p1;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Self-checking bench for johnson_phase_monitor: directed scenarios plus
// random stimulus, compared every cycle against a behavioural model.
module tb_johnson_phase_monitor;

  localparam int N    = 4;
  localparam int NPH  = 2 * N;
  localparam int LOCK = 4;

  localparam int M_SEARCH = 0;
  localparam int M_TRACK  = 1;
  localparam int M_LOCKED = 2;
  localparam int M_FAULT  = 3;

  logic         Clock = 1'b0;
  logic         Reset_n;
  logic [N-1:0] Count_in;
  logic         Clear_err;
  logic [2:0]   Phase_out;
  logic [7:0]   Phase_onehot;
  logic         Phase_valid;
  logic         Locked;
  logic         Error;
  logic [7:0]   Rev_count;
  logic         Rev_tick;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_state, m_run, m_prev, m_valid, m_err, m_rev, m_tick;
  int drv_ph;

  johnson_phase_monitor #(.WIDTH(N), .LOCK_COUNT(LOCK), .REV_W(8)) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .Count_in     (Count_in),
    .Clear_err    (Clear_err),
    .Phase_out    (Phase_out),
    .Phase_onehot (Phase_onehot),
    .Phase_valid  (Phase_valid),
    .Locked       (Locked),
    .Error        (Error),
    .Rev_count    (Rev_count),
    .Rev_tick     (Rev_tick)
  );

  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Johnson code for phase p: the counter fills with ones from the LSB,
  // then drains them from the LSB.
  function automatic int code_of(int p);
    if (p <= N) return (1 << p) - 1;
    return ((1 << N) - 1) & ~((1 << (p - N)) - 1);
  endfunction

  function automatic int phase_of(int c);
    for (int p = 0; p < NPH; p++)
      if (code_of(p) == c) return p;
    return -1;
  endfunction

  task automatic model_reset();
    m_state = M_SEARCH; m_run = 0; m_prev = 0; m_valid = 0;
    m_err = 0; m_rev = 0; m_tick = 0;
  endtask

  task automatic model_update();
    int ph, ns, nerr;
    bit legal, hold, step;
    if (!Reset_n) begin
      model_reset();
      return;
    end
    ph    = phase_of(int'(Count_in));
    legal = (ph >= 0);
    hold  = legal && (ph == m_prev);
    step  = legal && (ph == (m_prev + 1) % NPH);
    m_tick = (m_state == M_LOCKED && step && m_prev == NPH - 1) ? 1 : 0;
    if (m_tick == 1) m_rev = (m_rev + 1) % 256;
    ns   = m_state;
    nerr = Clear_err ? 0 : m_err;
    case (m_state)
      M_SEARCH: if (legal) begin ns = M_TRACK; m_run = 0; end
      M_TRACK: begin
        if (step) begin
          m_run++;
          if (m_run == LOCK) ns = M_LOCKED;
        end else if (!hold) ns = M_SEARCH;
      end
      M_LOCKED: if (!(step || hold)) begin ns = M_FAULT; nerr = 1; end
      default: if (Clear_err) ns = M_SEARCH;
    endcase
    m_state = ns;
    m_err   = nerr;
    m_valid = legal ? 1 : 0;
    if (legal) m_prev = ph;
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".phase"},  Phase_out,    m_prev);
    check_val({tag, ".onehot"}, Phase_onehot, (m_valid != 0) ? (1 << m_prev) : 0);
    check_val({tag, ".valid"},  Phase_valid,  m_valid);
    check_val({tag, ".locked"}, Locked,       (m_state == M_LOCKED) ? 1 : 0);
    check_val({tag, ".error"},  Error,        m_err);
    check_val({tag, ".rev"},    Rev_count,    m_rev);
    check_val({tag, ".tick"},   Rev_tick,     m_tick);
  endtask

  task automatic edge_check(input string tag);
    @(posedge Clock);
    model_update();
    #1;
    check_all(tag);
  endtask

  task automatic cycle(input int code, input bit clr, input string tag);
    @(negedge Clock);
    Count_in  = N'(code);
    Clear_err = clr;
    edge_check(tag);
  endtask

  // Drive n legal successor steps from the generator phase.
  task automatic run_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      drv_ph = (drv_ph + 1) % NPH;
      cycle(code_of(drv_ph), 1'b0, tag);
    end
  endtask

  task automatic release_reset(input string tag);
    @(negedge Clock);
    Reset_n   = 1'b1;
    Count_in  = '0;
    Clear_err = 1'b0;
    drv_ph    = 0;
    edge_check(tag);
  endtask

  initial begin
    int bad;
    model_reset();
    Reset_n = 1'b0; Count_in = '0; Clear_err = 1'b0; drv_ph = 0;

    // Reset held with random input
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      Count_in = N'($urandom_range(0, 15));
      edge_check("rst_hold");
    end
    release_reset("rst_rel");
    check_val("rel_valid", Phase_valid, 1);
    check_val("rel_locked", Locked, 0);

    // Lock acquisition: 0000 was sampled on release, four more steps
    run_steps(4, "lock");
    check_val("lock_locked", Locked, 1);
    check_val("lock_phase", Phase_out, 4);
    check_val("lock_onehot", Phase_onehot, 8'h10);

    // First revolution
    run_steps(4, "rev1");
    check_val("rev1_tick", Rev_tick, 1);
    check_val("rev1_count", Rev_count, 1);

    // Wrap the revolution counter
    for (int r = 0; r < 255; r++) run_steps(NPH, "wrap");
    check_val("wrap_count", Rev_count, 0);
    check_val("wrap_tick", Rev_tick, 1);

    // Async reset mid-operation with Rev_count=5
    for (int r = 0; r < 5; r++) run_steps(NPH, "rev5");
    run_steps(3, "rev5");
    check_val("rev5_count", Rev_count, 5);
    check_val("rev5_locked", Locked, 1);
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    check_val("async_locked", Locked, 0);
    edge_check("async_hold");
    release_reset("async_rel");

    // Fault on illegal code, clear, relock
    run_steps(6, "relock");
    check_val("relock_locked", Locked, 1);
    cycle(4'b0101, 1'b0, "bad");
    check_val("bad_error", Error, 1);
    check_val("bad_locked", Locked, 0);
    check_val("bad_valid", Phase_valid, 0);
    check_val("bad_phase", Phase_out, drv_ph);
    cycle(4'b0101, 1'b1, "clr");
    check_val("clr_error", Error, 0);
    run_steps(4, "clr_track");
    check_val("clr_not_yet", Locked, 0);
    run_steps(1, "clr_lock");
    check_val("clr_relock", Locked, 1);

    // Hold versus skip while locked
    while (drv_ph != 2) run_steps(1, "to2");
    for (int i = 0; i < 3; i++) cycle(code_of(2), 1'b0, "hold");
    check_val("hold_error", Error, 0);
    check_val("hold_locked", Locked, 1);
    cycle(code_of(4), 1'b0, "skip");
    check_val("skip_error", Error, 1);
    check_val("skip_locked", Locked, 0);
    cycle(code_of(4), 1'b1, "skip_clr");
    check_val("skip_clr_err", Error, 0);

    // Same jump in TRACK with run=2: no error
    cycle(code_of(0), 1'b0, "trk0");
    cycle(code_of(1), 1'b0, "trk1");
    cycle(code_of(2), 1'b0, "trk2");
    cycle(code_of(4), 1'b0, "trk_skip");
    check_val("trk_skip_err", Error, 0);
    check_val("trk_skip_lock", Locked, 0);
    drv_ph = 4;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int sel;
      bit clr;
      sel = $urandom_range(0, 99);
      clr = ($urandom_range(0, 99) < 4);
      if (sel < 72) begin
        drv_ph = (drv_ph + 1) % NPH;
        cycle(code_of(drv_ph), clr, "rnd_step");
      end else if (sel < 84) begin
        cycle(code_of(drv_ph), clr, "rnd_hold");
      end else if (sel < 92) begin
        drv_ph = (drv_ph + 2 + $urandom_range(0, NPH - 3)) % NPH;
        cycle(code_of(drv_ph), clr, "rnd_skip");
      end else begin
        do bad = $urandom_range(0, 15); while (phase_of(bad) >= 0);
        cycle(bad, clr, "rnd_bad");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/johnson_phase_monitor.md
Name: johnson_phase_monitor

Overview:
- Sits directly downstream of the 4-bit Johnson ring counter and consumes its Count_out bus every clock.
- Decodes the Johnson code into a binary phase index and a one-hot phase vector.
- Checks that the sequence is legal, declares lock, flags sequence faults, and counts completed revolutions.
- Used by phase-sequencing logic that needs a trusted phase plus a health/lock indication.

Parameters:
- WIDTH, 4, Johnson counter width N; legal sequence has 2N states.
- LOCK_COUNT, 4, consecutive legal successor steps needed to declare lock (1..2N).
- REV_W, 8, width of the revolution counter.

Ports:
- Clock  in  1  system clock, all state updates on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Count_in  in  WIDTH  Johnson code from the upstream counter.
- Clear_err  in  1  synchronous clear of sticky Error; returns FSM to SEARCH.
- Phase_out  out  clog2(2*WIDTH)  decoded phase index of last legal sample.
- Phase_onehot  out  2*WIDTH  one-hot of Phase_out; all zero when Phase_valid=0.
- Phase_valid  out  1  last sample was a legal Johnson code.
- Locked  out  1  high while FSM is in LOCKED.
- Error  out  1  sticky sequence-fault flag.
- Rev_count  out  REV_W  completed revolutions while locked, wraps modulo 2^REV_W.
- Rev_tick  out  1  one-cycle pulse per completed revolution.

Behaviour:
- Reset values: Reset_n=0 asynchronously forces all outputs to 0, the FSM to SEARCH, the run counter to 0, and the previous-phase register to 0. This applies mid-operation too.
- Decode (WIDTH=4): 0000→0, 0001→1, 0011→2, 0111→3, 1111→4, 1110→5, 1100→6, 1000→7.
  - General rule: k ones packed from the LSB → k.
  - N−k ones packed from the MSB (k zeros from the LSB, 0<k<N) → N+k.
  - Any other code is illegal.
- Latency: Count_in is sampled on each rising edge. Phase_out, Phase_onehot and Phase_valid update on that same edge, so they reflect the sample one cycle after it is presented.
  - On an illegal sample, Phase_out holds its old value, Phase_valid=0 and Phase_onehot=0.
- Sample classes, each compared with the previous legal phase P:
  - HOLD: same as P.
  - STEP: equals (P+1) mod 2N.
  - SKIP: legal, but neither HOLD nor STEP.
  - BAD: illegal code.
- FSM states and transitions:
  - SEARCH: on a legal sample → TRACK with run=0. On BAD → stay.
  - TRACK:
    - STEP → run+1; if the new run equals LOCK_COUNT → LOCKED.
    - HOLD → stay, run unchanged.
    - SKIP or BAD → SEARCH. No Error is raised in this state.
  - LOCKED:
    - STEP or HOLD → stay. HOLD is legal, e.g. the upstream counter is held in reset at 0000.
    - SKIP or BAD → FAULT, with Error=1 and Locked=0 on the same edge.
  - FAULT:
    - Error stays high and samples are ignored apart from decode.
    - Clear_err=1 → SEARCH with Error=0 on the next edge.
- Clear_err in any other state clears Error only, with no state change. In FAULT, Clear_err wins over a simultaneous new BAD/SKIP.
- Revolution counting:
  - Applies only when the state before the edge is LOCKED and the sample is a STEP from 2N−1 to 0.
  - On that edge Rev_count increments (wrapping 2^REV_W−1 → 0) and Rev_tick=1 for that one cycle.
  - Rev_count holds through FAULT/SEARCH and is cleared only by reset.
- Lock timing example: samples 0000,0001,0011,0111,1111 on edges e0..e4 → Locked rises after e4 (LOCK_COUNT=4).

Test Plan:
- Reset: hold Reset_n=0 with random Count_in → all outputs 0. Release on 0000 → Phase_valid=1, Phase_out=0, Locked=0.
- Lock acquisition: drive the legal sequence 0000,0001,0011,0111,1111 → Locked=1 after the 5th edge, Phase_out=4, Phase_onehot=00010000.
- Revolution: continue 1110,1100,1000,0000 → Rev_tick pulses on the edge sampling 0000 and Rev_count=1. Run 256 revolutions → Rev_count wraps to 0 with Rev_tick still pulsing.
- Fault, illegal code: while locked inject 0101 → Error=1, Locked=0, Phase_valid=0, Phase_out holds. Pulse Clear_err → Error=0, FSM in SEARCH, relock after 4 more steps.
- Hold versus skip:
  - Locked at 0011, hold 0011 for 3 cycles → no Error, Locked stays 1.
  - Then jump to 1111 → Error=1.
  - In TRACK with run=2, the same jump → back to SEARCH with no Error.
- Async reset mid-operation: assert Reset_n=0 between clock edges while locked with Rev_count=5 → all outputs 0 immediately, without waiting for a clock edge.
